// File: rtl/instr_encoder.sv
// RV32I instruction-word encoder (I/S/B, optional J) with range checking and a
// valid/ready output FIFO. Define INSTR_ENCODER_J_EN to enable J-type encoding.
module instr_encoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [31:0] NOP  = 32'h0000_0013;

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;
`ifdef INSTR_ENCODER_J_EN
  localparam logic [1:0] FMT_J = 2'b11;
`endif

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   mem_instr [DEPTH];
  logic          mem_err   [DEPTH];

  logic signed [31:0] imm_s;
  logic [31:0]        enc_word;
  logic               enc_ok;
  logic               push, pop;

  assign imm_s = in_imm;

  // NOTE: every combinational output gets a default first so no path through the case infers a latch.
  always_comb begin
    enc_word = NOP;
    enc_ok   = 1'b0;
    case (in_fmt)
      FMT_I: begin
        enc_ok   = (imm_s >= -2048) && (imm_s <= 2047);
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_S: begin
        enc_ok   = (imm_s >= -2048) && (imm_s <= 2047);
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      FMT_B: begin
        enc_ok   = (imm_s >= -4096) && (imm_s <= 4094) && !in_imm[0];
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
      end
`ifdef INSTR_ENCODER_J_EN
      FMT_J: begin
        enc_ok   = (imm_s >= -1048576) && (imm_s <= 1048574) && !in_imm[0];
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
`endif
      default: begin
        enc_ok   = 1'b0;
        enc_word = NOP;
      end
    endcase
  end

  // in_ready looks at registered count only, so a full FIFO refuses even on a pop cycle.
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_instr = out_valid ? mem_instr[rd_ptr] : 32'h0;
  assign out_err   = out_valid ? mem_err[rd_ptr]   : 1'b0;

  // NOTE: storage is not reset; out_instr/out_err are masked by out_valid, so stale entries never show.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= enc_ok ? enc_word : NOP;
      mem_err[wr_ptr]   <= !enc_ok;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !enc_ok && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=2); J expectations
// follow INSTR_ENCODER_J_EN.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ec   = 0;

  instr_encoder #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
  endtask

  // One request presented for exactly one edge; outputs sampled 1 time unit later.
  task automatic push(input logic [1:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [31:0] imm);
    set_req(fmt, op, rd, rs1, rs2, f3, imm);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] word, input logic err);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_instr"}, out_instr, word);
    check({tag, "_err"}, 32'(out_err), 32'(err));
    if (err && exp_ec < 255) exp_ec++;
    check({tag, "_errcnt"}, 32'(err_cnt), 32'(exp_ec));
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(2'b00, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    cycle(2);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_instr", out_instr, 32'h0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_errcnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    cycle(1);

    push(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, -32'sd1);
    expect_word("i_m1", 32'hFFF0_0093, 1'b0);
    push(2'b01, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    expect_word("s_8", 32'h0020_A423, 1'b0);
    push(2'b10, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4);
    expect_word("b_m4", 32'hFE00_0EE3, 1'b0);
    push(2'b10, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
    expect_word("b_odd", 32'h0000_0013, 1'b1);
    push(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    expect_word("i_2048", 32'h0000_0013, 1'b1);
    push(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2047);
    expect_word("i_2047", 32'h7FF0_0093, 1'b0);
    push(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, -32'sd2048);
    expect_word("i_m2048", 32'h8000_0093, 1'b0);
    push(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, -32'sd2049);
    expect_word("i_m2049", 32'h0000_0013, 1'b1);
    push(2'b10, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4094);
    expect_word("b_4094", 32'h7E00_0FE3, 1'b0);
    push(2'b10, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4096);
    expect_word("b_m4096", 32'h8000_0063, 1'b0);
    push(2'b10, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4096);
    expect_word("b_4096", 32'h0000_0013, 1'b1);

    push(2'b11, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8);
`ifdef INSTR_ENCODER_J_EN
    expect_word("j_8", 32'h0080_00EF, 1'b0);
    push(2'b11, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, -32'sd1048576);
    expect_word("j_min", 32'h8000_00EF, 1'b0);
    push(2'b11, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1048576);
    expect_word("j_over", 32'h0000_0013, 1'b1);
`else
    expect_word("j_off", 32'h0000_0013, 1'b1);
`endif

    // Error counter saturation.
    in_valid = 1'b1;
    set_req(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5000);
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("errcnt_sat", 32'(err_cnt), 32'd255);
    cycle(2);
    check("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: A, B fill the FIFO, C is held off.
    rst_n = 1'b0; cycle(1); rst_n = 1'b1; exp_ec = 0;
    check("bp_rst_errcnt", 32'(err_cnt), 32'd0);
    out_ready = 1'b0;
    push(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    check("bp_ready1", 32'(in_ready), 32'd1);
    push(2'b00, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2);
    check("bp_full", 32'(in_ready), 32'd0);
    set_req(2'b00, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd3);
    in_valid = 1'b1;
    cycle(1);
    check("bp_held_ready", 32'(in_ready), 32'd0);
    check("bp_hold_a", out_instr, 32'h0010_0093);
    out_ready = 1'b1;
    cycle(1);
    check("bp_ready_after_pop", 32'(in_ready), 32'd1);
    check("bp_b", out_instr, 32'h0020_0113);
    cycle(1);
    in_valid = 1'b0;
    check("bp_c", out_instr, 32'h0030_0193);
    check("bp_c_valid", 32'(out_valid), 32'd1);
    cycle(1);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Reset with entries queued.
    out_ready = 1'b0;
    push(2'b10, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd1);
    push(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd7);
    check("mid_errcnt", 32'(err_cnt), 32'd1);
    check("mid_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    cycle(1);
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_errcnt", 32'(err_cnt), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
